// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: one fetch in flight, fixed-latency response,
// abort (redirect) support, and a write-only preload port.
module imem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        abort,
    output logic        rsp_valid,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    output logic        stall_f,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cntNext;
    logic [31:0]        addrQ;
    logic [31:0]        addrNext;
    logic               rspValidQ;
    logic               rspLoad;
    logic               accept;
    logic               reqErr;
    logic [IDX_W-1:0]   reqIdx;
    logic [31:0]        mem [DEPTH];

    assign req_ready = (state != WAIT) || abort;
    assign stall_f   = (state == WAIT);
    assign rsp_valid = rspValidQ && !abort;
    assign accept    = req_valid && req_ready;

    // Full-width index compare so out-of-range PCs never alias into the array.
    assign reqErr = (addrQ[1:0] != 2'b00) || (addrQ[31:2] >= 30'(DEPTH));
    assign reqIdx = addrQ[IDX_W+1:2];

    // Next-state and counter control.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        addrNext  = addrQ;
        rspLoad   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = WAIT;
                    cntNext   = CNT_W'(LATENCY - 1);
                    addrNext  = req_addr;
                end
            end
            WAIT: begin
                if (abort) begin
                    if (req_valid) begin
                        stateNext = WAIT;
                        cntNext   = CNT_W'(LATENCY - 1);
                        addrNext  = req_addr;
                    end else begin
                        stateNext = IDLE;
                    end
                end else if (cnt == '0) begin
                    stateNext = RESP;
                    rspLoad   = 1'b1;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (accept) begin
                    stateNext = WAIT;
                    cntNext   = CNT_W'(LATENCY - 1);
                    addrNext  = req_addr;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addrQ     <= '0;
            rspValidQ <= 1'b0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            addrQ     <= addrNext;
            rspValidQ <= rspLoad;
            if (rspLoad) begin
                rsp_addr  <= addrQ;
                rsp_err   <= reqErr;
                rsp_instr <= reqErr ? NOP : mem[reqIdx];
            end
        end
    end

    // Preload port; not reset. Same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en && (ld_addr < 32'(DEPTH))) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus a randomized run
// against a cycle-level behavioural model (due-edge arithmetic, array memory).
module tb_imem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        abort;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        stall_f;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int errors = 0;
    int checks = 0;
    logic [31:0] refMem [DEPTH];

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .abort(abort), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .stall_f(stall_f), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int unsigned idx, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = idx; ld_data = d;
        tick();
        ld_en = 1'b0;
        if (idx < DEPTH) refMem[idx] = d;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL reset_stall_f got=%b exp=0", stall_f); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_rsp_instr got=%h exp=0", rsp_instr); end
        checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL reset_rsp_addr got=%h exp=0", rsp_addr); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    endtask

    task automatic test_basic();
        req_valid = 1'b1; req_addr = 32'h0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", req_ready); end
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (stall_f !== (i <= 2)) begin errors++; $display("FAIL basic_stall c%0d got=%b exp=%b", i, stall_f, (i <= 2)); end
            checks++; if (rsp_valid !== (i == 3)) begin errors++; $display("FAIL basic_rsp_valid c%0d got=%b exp=%b", i, rsp_valid, (i == 3)); end
            if (i == 3) begin
                checks++; if (rsp_instr !== 32'h00500093) begin errors++; $display("FAIL basic_instr got=%h exp=00500093", rsp_instr); end
                checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL basic_addr got=%h exp=0", rsp_addr); end
                checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", rsp_err); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int nrsp = 0;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        for (int i = 1; i <= 10; i++) begin
            checks++; if (rsp_valid !== (i % 3 == 0)) begin errors++; $display("FAIL b2b_rsp_valid c%0d got=%b exp=%b", i, rsp_valid, (i % 3 == 0)); end
            checks++; if (stall_f !== ((i < 9) && (i % 3 != 0))) begin errors++; $display("FAIL b2b_stall c%0d got=%b", i, stall_f); end
            if (rsp_valid) begin
                nrsp++;
                checks++; if (rsp_addr !== 32'(idx * 4)) begin errors++; $display("FAIL b2b_addr got=%h exp=%h", rsp_addr, 32'(idx * 4)); end
                checks++; if (rsp_instr !== refMem[idx]) begin errors++; $display("FAIL b2b_instr got=%h exp=%h", rsp_instr, refMem[idx]); end
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp got=%b exp=1", req_ready); end
                idx++;
                if (idx < 3) req_addr = 32'(idx * 4);
                else req_valid = 1'b0;
            end
            tick();
        end
        checks++; if (nrsp != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nrsp); end
    endtask

    task automatic test_abort();
        req_valid = 1'b1; req_addr = 32'h10;
        tick();
        abort = 1'b1; req_addr = 32'h40;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL abort_stall got=%b exp=1", stall_f); end
        tick();
        abort = 1'b0; req_valid = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            checks++; if (rsp_valid !== (i == 2)) begin errors++; $display("FAIL abort_rsp_valid c%0d got=%b exp=%b", i, rsp_valid, (i == 2)); end
            if (i == 2) begin
                checks++; if (rsp_addr !== 32'h40) begin errors++; $display("FAIL abort_addr got=%h exp=40", rsp_addr); end
                checks++; if (rsp_instr !== refMem[16]) begin errors++; $display("FAIL abort_instr got=%h exp=%h", rsp_instr, refMem[16]); end
            end
            tick();
        end
        // Abort landing in the response cycle: pulse suppressed, new request still taken.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_resp_suppress got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_resp_ready got=%b exp=1", req_ready); end
        tick();
        abort = 1'b0; req_valid = 1'b0;
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL abort_resp_accept got=%b exp=1", stall_f); end
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL abort_resp_next_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_addr !== 32'h4) begin errors++; $display("FAIL abort_resp_next_addr got=%h exp=4", rsp_addr); end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic        expErr [3];
        logic [31:0] expInstr [3];
        addrs[0] = 32'h6;               expErr[0] = 1'b1; expInstr[0] = 32'h13;
        addrs[1] = 32'(4 * DEPTH);      expErr[1] = 1'b1; expInstr[1] = 32'h13;
        addrs[2] = 32'(4 * DEPTH - 4);  expErr[2] = 1'b0; expInstr[2] = refMem[DEPTH-1];
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = addrs[k];
            tick();
            req_valid = 1'b0;
            for (int j = 0; j < int'(LATENCY); j++) tick();
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err_valid a=%h got=%b exp=1", addrs[k], rsp_valid); end
            checks++; if (rsp_err !== expErr[k]) begin errors++; $display("FAIL err_flag a=%h got=%b exp=%b", addrs[k], rsp_err, expErr[k]); end
            checks++; if (rsp_instr !== expInstr[k]) begin errors++; $display("FAIL err_instr a=%h got=%h exp=%h", addrs[k], rsp_instr, expInstr[k]); end
            checks++; if (rsp_addr !== addrs[k]) begin errors++; $display("FAIL err_addr got=%h exp=%h", rsp_addr, addrs[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp c%0d got=%b exp=0", i, rsp_valid); end
        end
    endtask

    task automatic test_ld_collision();
        logic [31:0] oldV;
        logic [31:0] newV;
        oldV = refMem[2];
        newV = oldV ^ ($urandom | 32'h1);
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        ld_en = 1'b1; ld_addr = 32'd2; ld_data = newV;
        tick();
        ld_en = 1'b0;
        refMem[2] = newV;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ldcol_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_instr !== oldV) begin errors++; $display("FAIL ldcol_old got=%h exp=%h", rsp_instr, oldV); end
        tick();
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++; if (rsp_instr !== newV) begin errors++; $display("FAIL ldcol_new got=%h exp=%h", rsp_instr, newV); end
        tick();
    endtask

    task automatic test_random();
        bit          pending = 1'b0;
        bit          respNow = 1'b0;
        bit          acc;
        bit          newResp;
        int          edgeNo = 0;
        int          due = 0;
        logic [31:0] pAddr = '0;
        logic [31:0] eAddr = '0;
        logic [31:0] eInstr = '0;
        logic        eErr = 1'b0;
        int          r;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       req_addr = 32'($urandom_range(0, 15) * 4);
            else if (r == 7) req_addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 8) req_addr = 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
            else             req_addr = 32'(4 * (DEPTH - 1));
            req_valid = ($urandom_range(0, 1) == 1);
            abort     = ($urandom_range(0, 7) == 0);
            ld_en     = ($urandom_range(0, 3) == 0);
            ld_addr   = ($urandom_range(0, 4) == 0) ? 32'(DEPTH + $urandom_range(0, 3)) : 32'($urandom_range(0, 15));
            ld_data   = $urandom;
            #1;
            checks++; if (stall_f !== pending) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_f, pending); end
            checks++; if (req_ready !== (!pending || abort)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, req_ready, (!pending || abort)); end
            checks++; if (rsp_valid !== (respNow && !abort)) begin errors++; $display("FAIL rnd_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, (respNow && !abort)); end
            if (respNow) begin
                checks++; if (rsp_addr !== eAddr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, rsp_addr, eAddr); end
                checks++; if (rsp_err !== eErr) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, rsp_err, eErr); end
                checks++; if (rsp_instr !== eInstr) begin errors++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, rsp_instr, eInstr); end
            end
            // Advance the model across the coming edge.
            acc     = req_valid && (!pending || abort);
            newResp = pending && !abort && (edgeNo + 1 == due);
            if (newResp) begin
                eAddr  = pAddr;
                eErr   = (pAddr % 4 != 0) || ((pAddr / 4) >= DEPTH);
                eInstr = eErr ? 32'h13 : refMem[pAddr / 4];
            end
            respNow = newResp;
            if (acc) begin
                pending = 1'b1; pAddr = req_addr; due = edgeNo + 1 + int'(LATENCY);
            end else if (newResp || (pending && abort)) begin
                pending = 1'b0;
            end
            if (ld_en && ld_addr < DEPTH) refMem[ld_addr] = ld_data;
            tick();
            edgeNo++;
        end
        req_valid = 1'b0; abort = 1'b0; ld_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; abort = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        preload(0, 32'h00500093);
        for (int i = 1; i < 32; i++) preload(i, $urandom);
        preload(DEPTH - 1, $urandom);
        tick();
        test_basic();
        test_back_to_back();
        test_abort();
        test_errors();
        test_reset_mid();
        test_ld_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
